mem_responder: RTL and testbench

Memory-side responder for the cache-to-memory request interface. Services instruction-fill requests from the icache and read/write requests from the dcache against a single variable-latency RAM port. Sits between the cache pair and the RAM model/controller. Arbitrates one access at a time, drives the per-requester wait/data responses and keeps saturating access counters.

---
 rtl/mem_responder.sv | 120 ++++++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates icache fills and dcache reads/writes onto one
// variable-latency RAM port, with dcache priority and saturating completion counters.
module mem_responder #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ram_ack,
   output logic [CNT_W-1:0]  icount,
   output logic [CNT_W-1:0]  dcount
);

   typedef enum logic [1:0] {IDLE, IACC, DACC} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] store_q, store_d;
   logic [CNT_W-1:0]  icount_q, icount_d;
   logic [CNT_W-1:0]  dcount_q, dcount_d;

   // State and latched-request registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         icount_q <= '0;
         dcount_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         icount_q <= icount_d;
         dcount_q <= dcount_d;
      end
   end

   // Next state, request latching, strobes and ack-driven responses
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      store_d  = store_q;
      icount_d = icount_q;
      dcount_d = dcount_q;
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;

      case (state_q)
         IDLE: begin
            if (dREN || dWEN) begin
               addr_d  = daddr;
               store_d = dstore;
               we_d    = dWEN;
               state_d = DACC;
            end else if (iREN) begin
               addr_d  = iaddr;
               state_d = IACC;
            end
         end
         IACC: begin
            ramREN = 1'b1;
            if (ram_ack) begin
               state_d = IDLE;
               // A dropped request still completes at the RAM, silently
               if (iREN) begin
                  iwait = 1'b0;
                  iload = ramload;
               end
            end
         end
         DACC: begin
            ramREN = ~we_q;
            ramWEN = we_q;
            if (ram_ack) begin
               state_d = IDLE;
               if (we_q ? dWEN : dREN) begin
                  dwait = 1'b0;
                  if (!we_q) dload = ramload;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (!iwait && icount_q != CNT_MAX) icount_d = icount_q + CNT_W'(1);
      if (!dwait && dcount_q != CNT_MAX) dcount_d = dcount_q + CNT_W'(1);
   end

   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign icount   = icount_q;
   assign dcount   = dcount_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM model with programmable ack latency and a
// response scoreboard; a second instance with CNT_W=2 checks counter saturation.
module tb_mem_responder;

   logic        CLK, RST;
   logic        iREN, dREN, dWEN, ram_ack;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [15:0] icount, dcount;

   logic        s_iwait, s_dwait, s_ramREN, s_ramWEN;
   logic [31:0] s_iload, s_dload, s_ramaddr, s_ramstore;
   logic [1:0]  s_icount, s_dcount;

   mem_responder dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ack(ram_ack), .icount(icount), .dcount(dcount)
   );

   mem_responder #(.CNT_W(2)) u_sat (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(s_iwait), .iload(s_iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(s_dwait), .dload(s_dload),
      .ramREN(s_ramREN), .ramWEN(s_ramWEN), .ramaddr(s_ramaddr), .ramstore(s_ramstore),
      .ramload(ramload), .ram_ack(ram_ack), .icount(s_icount), .dcount(s_dcount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          tests = 0;
   int          fails = 0;
   int          cyc_n = 0;
   int          ipulses = 0, dpulses = 0;
   int          i_last = 0, d_last = 0;
   int          ack_lat = 3;
   int          rcnt = 0;
   bit          ram_auto = 1'b1;
   bit          strobe_prev = 1'b0;
   logic [31:0] iq[$];
   logic [31:0] dq[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM contents as seen by the model
   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
   endfunction

   // One clock cycle: RAM model drives ack, responses are scored at the falling edge
   task automatic cyc();
      logic strobe;
      strobe = ramREN | ramWEN;
      if (strobe && !strobe_prev) rcnt = 0;
      else if (strobe) rcnt++;
      if (ram_auto) begin
         ram_ack = strobe && (rcnt == ack_lat);
         ramload = ram_ack ? ram_rd(ramaddr) : 32'hBAD0_BAD0;
      end
      @(negedge CLK);
      if (iwait === 1'b0) begin
         ipulses++;
         i_last = cyc_n;
         if (iq.size() == 0) chk("i_pulse_expected", 64'(iq.size()), 64'd1);
         else chk("iload", iload, iq.pop_front());
      end else chk("iload_idle", iload, 32'h0);
      if (dwait === 1'b0) begin
         dpulses++;
         d_last = cyc_n;
         if (dq.size() == 0) chk("d_pulse_expected", 64'(dq.size()), 64'd1);
         else chk("dload", dload, dq.pop_front());
      end else chk("dload_idle", dload, 32'h0);
      strobe_prev = strobe;
      @(posedge CLK);
      #1;
      cyc_n++;
   endtask

   task automatic wait_i(input int target);
      int n = 0;
      while (ipulses < target && n < 30) begin cyc(); n++; end
      chk("i_done", 64'(ipulses), 64'(target));
   endtask

   task automatic wait_d(input int target);
      int n = 0;
      while (dpulses < target && n < 30) begin cyc(); n++; end
      chk("d_done", 64'(dpulses), 64'(target));
   endtask

   task automatic chk_reset_outs();
      chk("rst_iwait", iwait, 1'b1);
      chk("rst_dwait", dwait, 1'b1);
      chk("rst_iload", iload, 32'h0);
      chk("rst_dload", dload, 32'h0);
      chk("rst_ramREN", ramREN, 1'b0);
      chk("rst_ramWEN", ramWEN, 1'b0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
      chk("rst_icount", icount, 16'h0);
      chk("rst_dcount", dcount, 16'h0);
   endtask

   initial begin
      int s;
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ack = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outs();
      RST = 1'b0;
      cyc();

      // icache read, ack 3 cycles after strobe
      iREN = 1'b1; iaddr = 32'h40; iq.push_back(32'hDEAD_BEEF);
      s = cyc_n;
      cyc();
      chk("t1_ramREN", ramREN, 1'b1);
      chk("t1_ramWEN", ramWEN, 1'b0);
      chk("t1_ramaddr", ramaddr, 32'h40);
      wait_i(1);
      iREN = 1'b0;
      chk("t1_latency", 64'(i_last - s), 64'd4);
      repeat (2) cyc();
      chk("t1_icount", icount, 16'd1);
      chk("t1_no_dwait", 64'(dpulses), 64'd0);

      // dcache write, request fields change mid-access
      dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678; dq.push_back(32'h0);
      cyc();
      chk("t2_ramWEN", ramWEN, 1'b1);
      chk("t2_ramREN", ramREN, 1'b0);
      chk("t2_ramaddr", ramaddr, 32'h100);
      chk("t2_ramstore", ramstore, 32'h1234_5678);
      daddr = 32'hFFFF_0000; dstore = 32'h5555_AAAA;
      cyc();
      chk("t2_hold_addr", ramaddr, 32'h100);
      chk("t2_hold_store", ramstore, 32'h1234_5678);
      chk("t2_hold_WEN", ramWEN, 1'b1);
      wait_d(1);
      dWEN = 1'b0;
      cyc();
      chk("t2_dcount", dcount, 16'd1);
      chk("t2_icount", icount, 16'd1);

      // simultaneous requests: dcache first, one IDLE bubble, then icache
      ack_lat = 2;
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
      dq.push_back(ram_rd(32'h200)); iq.push_back(ram_rd(32'h80));
      s = cyc_n;
      cyc();
      chk("t3_ramREN_d", ramREN, 1'b1);
      chk("t3_ramaddr_d", ramaddr, 32'h200);
      wait_d(2);
      dREN = 1'b0;
      cyc();
      chk("t3_ramREN_i", ramREN, 1'b1);
      chk("t3_ramaddr_i", ramaddr, 32'h80);
      wait_i(2);
      iREN = 1'b0;
      chk("t3_d_latency", 64'(d_last - s), 64'd3);
      chk("t3_i_after_d", 64'(i_last - d_last), 64'd4);
      cyc();
      chk("t3_icount", icount, 16'd2);
      chk("t3_dcount", dcount, 16'd2);

      // icache request dropped after IACC entry
      ack_lat = 3;
      iREN = 1'b1; iaddr = 32'hC0;
      cyc();
      chk("t4_ramREN", ramREN, 1'b1);
      iREN = 1'b0;
      repeat (6) cyc();
      chk("t4_no_ipulse", 64'(ipulses), 64'd2);
      chk("t4_icount", icount, 16'd2);
      chk("t4_idle", ramREN, 1'b0);

      // reset during DACC, stray ack after release
      ram_auto = 1'b0; ram_ack = 1'b0; ramload = 32'hBAD0_BAD0;
      dREN = 1'b1; daddr = 32'h300;
      cyc();
      chk("t5_ramREN", ramREN, 1'b1);
      RST = 1'b1; dREN = 1'b0;
      #1;
      chk_reset_outs();
      repeat (2) cyc();
      RST = 1'b0;
      ram_ack = 1'b1; ramload = 32'h1111_2222;
      cyc();
      ram_ack = 1'b0; ramload = 32'hBAD0_BAD0;
      cyc();
      chk("t5_no_dpulse", 64'(dpulses), 64'd2);
      chk("t5_dcount", dcount, 16'd0);
      chk("t5_ramREN", ramREN, 1'b0);
      ram_auto = 1'b1;

      // five icache reads: CNT_W=2 instance saturates at 3
      ack_lat = 1;
      for (int k = 0; k < 5; k++) begin
         iREN = 1'b1; iaddr = 32'h400 + 32'(k * 4);
         iq.push_back(ram_rd(32'h400 + 32'(k * 4)));
         wait_i(3 + k);
         iREN = 1'b0;
         cyc();
         chk("t6_sat_icount", s_icount, (k < 2) ? 2'(k + 1) : 2'd3);
         chk("t6_icount", icount, 16'(k + 1));
      end

      chk("iq_empty", 64'(iq.size()), 64'd0);
      chk("dq_empty", 64'(dq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
